ddr3_stress_seq: RTL and testbench
==================================

Name: ddr3_stress_seq

Overview:
- Stress sequencer for the DDR3 memory-controller user interface; sits directly upstream of the controller and drives its command, write-data and init ports.
- Per run: starts controller init, writes a deterministic pattern over an address range, reads it back, compares every beat, and reports error and timeout status.
- Clocked by the controller's user clock (sclk_out), so no clock-domain crossing.

Parameters:
- ADDR_STEP, 8: address increment per command (controller address units).
- BEATS, 2: 128-bit user beats per command (cmd_burst_cnt = 1).
- CMD_WR, 4'b0010: controller write command code.
- CMD_RD, 4'b0001: controller read command code.
- TIMEOUT_CYC, 1023: maximum cycles waited for the beats of one command.

Ports:
- sclk  in  1  clock (connect to controller sclk_out)
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; starts a run when idle
- seed  in  32  pattern seed, sampled at start
- base_addr  in  28  first address, sampled at start
- cmd_count  in  16  commands per phase, sampled at start; 0 = 65536
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  last run had err_count == 0 and no timeout; held until next start
- err_count  out  16  mismatched read beats, saturating
- timeout  out  1  sticky per run; some command timed out
- init_start  out  1  to controller init_start
- init_done  in  1  from controller
- cmd  out  4  to controller
- addr  out  28  to controller
- cmd_burst_cnt  out  5  constant 5'd1
- ofly_burst_len  out  1  constant 0
- cmd_valid  out  1  to controller
- cmd_rdy  in  1  from controller
- datain_rdy  in  1  from controller
- write_data  out  128  to controller
- data_mask  out  16  constant 0
- read_data  in  128  from controller
- read_data_valid  in  1  from controller

Behaviour:
- Reset values: all outputs 0 except cmd_burst_cnt = 1; state IDLE.
- Pattern: for command index i and beat b, v = seed + i*BEATS + b (32-bit wrap); beat = {v, ~v, v, ~v}.
- Address: addr = base_addr + i*ADDR_STEP (28-bit wrap).
- IDLE: on start, latch inputs, clear err_count and timeout, set busy = 1.
  - If init_done = 1, go to WR_CMD; otherwise go to INIT.
  - start while busy is ignored.
- INIT: hold init_start = 1 until init_done = 1, then drop init_start and go to WR_CMD. init_start is asserted at most once per reset.
- WR_CMD: cmd_valid = 1, cmd = CMD_WR, addr(i).
  - Command accepted in the cycle where cmd_valid and cmd_rdy are both 1; that cycle go to WR_DATA.
  - cmd, addr and cmd_valid stay stable until accepted.
- WR_DATA: write_data presents beat b; b advances on each cycle with datain_rdy = 1.
  - After BEATS beats: i++; if i == cmd_count go to RD_CMD with i = 0, else go to WR_CMD.
  - datain_rdy seen in any other state is ignored.
- RD_CMD: same handshake as WR_CMD with cmd = CMD_RD; then go to RD_WAIT.
- RD_WAIT: each read_data_valid beat is compared to the expected beat(i, b); a mismatch increments err_count (saturates at 16'hFFFF).
  - After BEATS beats: i++, then go to RD_CMD, or to DONE after the last command.
  - read_data_valid outside RD_WAIT is ignored.
- Timeout: a cycle counter runs from entry to WR_DATA or RD_WAIT and clears on each beat.
  - Reaching TIMEOUT_CYC: set timeout, add the missing beats to err_count, advance to the next command.
  - A WR_DATA timeout skips the remaining write beats.
- DONE: one cycle; done = 1, pass updated, busy = 0, then go to IDLE.
- Simultaneous cmd_rdy and datain_rdy: datain_rdy before acceptance is ignored; write beats are counted only in WR_DATA.
- Reset mid-run: immediately to IDLE with reset values. init_start re-arms and is asserted again on the next start if init_done = 0.

Optional Feature:
- Macro DDR3_STRESS_ERR_CAPTURE_EN.
- Defined: extra outputs err_addr[27:0], err_exp[127:0], err_got[127:0] latch the address, expected beat and received beat of the first mismatch per run. They hold until the next start and are 0 at reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- init_done = 0, start, controller raises init_done after 50 cycles -> init_start high from the cycle after start until init_done, then exactly 1 write issued at base_addr.
- seed = 32'h1000, base_addr = 0, cmd_count = 4, ideal controller model -> writes at addr 0, 8, 16, 24; first beat {32'h1000, 32'hFFFFEFFF, 32'h1000, 32'hFFFFEFFF}; done with pass = 1 and err_count = 0.
- Same run, model corrupts read beat 3 (cmd 1, b 1) -> err_count = 1, pass = 0; with macro, err_addr = 8.
- cmd_rdy held low 20 cycles on the second write -> cmd_valid, cmd and addr stable throughout, accepted exactly once.
- Model drops the last read beat -> timeout = 1 after 1023 idle cycles, err_count = 1, done pulses.
- base_addr = 28'hFFFFFF8, cmd_count = 2 -> addresses 28'hFFFFFF8 then 28'h0000000; reset asserted mid-RD_WAIT -> busy = 0 and cmd_valid = 0 immediately.

Source files
------------

// File: rtl/ddr3_stress_seq.sv
// DDR3 user-interface stress sequencer: controller init, pattern write, read-back compare.
// Optional first-mismatch capture ports are built when DDR3_STRESS_ERR_CAPTURE_EN is defined.
module ddr3_stress_seq #(
    parameter int unsigned ADDR_STEP   = 8,
    parameter int unsigned BEATS       = 2,
    parameter logic [3:0]  CMD_WR      = 4'b0010,
    parameter logic [3:0]  CMD_RD      = 4'b0001,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic         sclk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  seed,
    input  logic [27:0]  base_addr,
    input  logic [15:0]  cmd_count,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_count,
    output logic         timeout,
    output logic         init_start,
    input  logic         init_done,
    output logic [3:0]   cmd,
    output logic [27:0]  addr,
    output logic [4:0]   cmd_burst_cnt,
    output logic         ofly_burst_len,
    output logic         cmd_valid,
    input  logic         cmd_rdy,
    input  logic         datain_rdy,
    output logic [127:0] write_data,
    output logic [15:0]  data_mask,
    input  logic [127:0] read_data,
    input  logic         read_data_valid
`ifdef DDR3_STRESS_ERR_CAPTURE_EN
    ,
    output logic [27:0]  err_addr,
    output logic [127:0] err_exp,
    output logic [127:0] err_got
`endif
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_WR_CMD  = 3'd2;
    localparam logic [2:0] S_WR_DATA = 3'd3;
    localparam logic [2:0] S_RD_CMD  = 3'd4;
    localparam logic [2:0] S_RD_WAIT = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]    state_q;
    logic [16:0]   idx_q;
    logic [16:0]   total_q;
    logic [31:0]   seed_q;
    logic [27:0]   base_q;
    logic [BW-1:0] beat_q;
    logic [TW-1:0] timer_q;
    logic [15:0]   err_count_q;
    logic          timeout_q;
    logic          pass_q;
    logic          busy_q;
    logic          done_q;
    logic          init_start_q;
    logic          init_fired_q;

    logic [31:0]   pat_v;
    logic [127:0]  exp_beat;
    logic [27:0]   addr_c;
    logic          in_wr_data;
    logic          in_rd_wait;
    logic          beat_hit;
    logic          mismatch;
    logic          timed_out;
    logic          last_beat;
    logic          cmd_done;
    logic          last_cmd;
    logic [16:0]   err_add;
    logic [16:0]   err_sum;
    logic [15:0]   err_next;
    logic          timeout_next;

    // Beat pattern and address are functions of the current command index and beat.
    assign pat_v    = seed_q + 32'(idx_q) * 32'(BEATS) + 32'(beat_q);
    assign exp_beat = {pat_v, ~pat_v, pat_v, ~pat_v};
    assign addr_c   = base_q + 28'(32'(idx_q) * ADDR_STEP);

    assign in_wr_data = (state_q == S_WR_DATA);
    assign in_rd_wait = (state_q == S_RD_WAIT);
    assign beat_hit   = (in_wr_data & datain_rdy) | (in_rd_wait & read_data_valid);
    assign mismatch   = in_rd_wait & read_data_valid & (read_data != exp_beat);
    assign timed_out  = (in_wr_data | in_rd_wait) & ~beat_hit &
                        (timer_q == TW'(TIMEOUT_CYC - 1));
    assign last_beat  = (beat_q == BW'(BEATS - 1));
    assign cmd_done   = (beat_hit & last_beat) | timed_out;
    assign last_cmd   = ((idx_q + 17'd1) == total_q);

    // A timeout charges every beat of the command that never arrived.
    always_comb begin
        err_add = 17'd0;
        if (mismatch)
            err_add = 17'd1;
        else if (timed_out)
            err_add = 17'(BEATS) - 17'(beat_q);
        err_sum      = {1'b0, err_count_q} + err_add;
        err_next     = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        timeout_next = timeout_q | timed_out;
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            total_q      <= '0;
            seed_q       <= '0;
            base_q       <= '0;
            beat_q       <= '0;
            timer_q      <= '0;
            err_count_q  <= '0;
            timeout_q    <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            init_start_q <= 1'b0;
            init_fired_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seed_q      <= seed;
                        base_q      <= base_addr;
                        total_q     <= (cmd_count == 16'd0) ? 17'h10000 : {1'b0, cmd_count};
                        idx_q       <= '0;
                        beat_q      <= '0;
                        timer_q     <= '0;
                        err_count_q <= '0;
                        timeout_q   <= 1'b0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        if (init_done) begin
                            state_q <= S_WR_CMD;
                        end else begin
                            state_q <= S_INIT;
                            if (!init_fired_q) begin
                                init_start_q <= 1'b1;
                                init_fired_q <= 1'b1;
                            end
                        end
                    end
                end
                S_INIT: begin
                    if (init_done) begin
                        init_start_q <= 1'b0;
                        state_q      <= S_WR_CMD;
                    end
                end
                S_WR_CMD, S_RD_CMD: begin
                    if (cmd_rdy) begin
                        beat_q  <= '0;
                        timer_q <= '0;
                        state_q <= (state_q == S_WR_CMD) ? S_WR_DATA : S_RD_WAIT;
                    end
                end
                S_WR_DATA, S_RD_WAIT: begin
                    err_count_q <= err_next;
                    timeout_q   <= timeout_next;
                    if (cmd_done) begin
                        beat_q  <= '0;
                        timer_q <= '0;
                        if (last_cmd) begin
                            idx_q <= '0;
                            if (in_wr_data) begin
                                state_q <= S_RD_CMD;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                pass_q  <= (err_next == 16'd0) && !timeout_next;
                            end
                        end else begin
                            idx_q   <= idx_q + 17'd1;
                            state_q <= in_wr_data ? S_WR_CMD : S_RD_CMD;
                        end
                    end else if (beat_hit) begin
                        beat_q  <= beat_q + 1'b1;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DDR3_STRESS_ERR_CAPTURE_EN
    logic          err_seen_q;
    logic [27:0]   err_addr_q;
    logic [127:0]  err_exp_q;
    logic [127:0]  err_got_q;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            err_seen_q <= 1'b0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else if (state_q == S_IDLE && start) begin
            err_seen_q <= 1'b0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else if (mismatch && !err_seen_q) begin
            err_seen_q <= 1'b1;
            err_addr_q <= addr_c;
            err_exp_q  <= exp_beat;
            err_got_q  <= read_data;
        end
    end

    assign err_addr = err_addr_q;
    assign err_exp  = err_exp_q;
    assign err_got  = err_got_q;
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign timeout        = timeout_q;
    assign init_start     = init_start_q;
    assign cmd_valid      = (state_q == S_WR_CMD) || (state_q == S_RD_CMD);
    assign cmd            = (state_q == S_WR_CMD) ? CMD_WR :
                            (state_q == S_RD_CMD) ? CMD_RD : 4'd0;
    assign addr           = addr_c;
    assign write_data     = in_wr_data ? exp_beat : 128'd0;
    assign cmd_burst_cnt  = 5'd1;
    assign ofly_burst_len = 1'b0;
    assign data_mask      = 16'd0;

endmodule

// File: tb/tb_ddr3_stress_seq.sv
// Scoreboard bench for ddr3_stress_seq: a controller model answers commands, a monitor
// pops expected commands, write beats and run results as the DUT presents them.
module tb_ddr3_stress_seq;

    localparam logic [3:0] CMD_WR = 4'b0010;
    localparam logic [3:0] CMD_RD = 4'b0001;

    logic         sclk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  seed;
    logic [27:0]  base_addr;
    logic [15:0]  cmd_count;
    logic         busy, done, pass, timeout, init_start, cmd_valid, ofly_burst_len;
    logic [15:0]  err_count, data_mask;
    logic         init_done;
    logic [3:0]   cmd;
    logic [27:0]  addr;
    logic [4:0]   cmd_burst_cnt;
    logic         cmd_rdy, datain_rdy, read_data_valid;
    logic [127:0] write_data, read_data;
`ifdef DDR3_STRESS_ERR_CAPTURE_EN
    logic [27:0]  err_addr;
    logic [127:0] err_exp, err_got;
`endif

    ddr3_stress_seq dut (
        .sclk(sclk), .rst(rst), .start(start), .seed(seed), .base_addr(base_addr),
        .cmd_count(cmd_count), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .timeout(timeout), .init_start(init_start),
        .init_done(init_done), .cmd(cmd), .addr(addr), .cmd_burst_cnt(cmd_burst_cnt),
        .ofly_burst_len(ofly_burst_len), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy),
        .datain_rdy(datain_rdy), .write_data(write_data), .data_mask(data_mask),
        .read_data(read_data), .read_data_valid(read_data_valid)
`ifdef DDR3_STRESS_ERR_CAPTURE_EN
        , .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got)
`endif
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [3:0]  cmd;
        logic [27:0] addr;
    } cmd_t;

    typedef struct {
        logic         pass;
        logic [15:0]  err;
        logic         tmo;
        logic [27:0]  eaddr;
        logic [127:0] eexp;
        logic [127:0] egot;
    } res_t;

    cmd_t         exp_cmd_q[$];
    logic [127:0] exp_wdata_q[$];
    res_t         exp_res_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Controller model state
    logic [127:0] mem [logic [28:0]];
    logic [127:0] rdq[$];
    int           wr_left = 0;
    logic [27:0]  wr_addr = '0;
    int           wr_cmds = 0;
    int           rd_cmds = 0;
    int           rd_beat_no = 0;
    int           stall_left = 0;
    int           corrupt_at = -1;
    int           drop_at = -1;

    // Monitor state
    int           stall_seen = 0;
    logic         held_valid = 1'b0;
    logic [3:0]   held_cmd;
    logic [27:0]  held_addr;
    logic         first_wdata_taken = 1'b0;
    logic [127:0] first_wdata = '0;

    function automatic logic [127:0] pattern(input logic [31:0] s, input int i, input int b);
        logic [31:0] v;
        v = s + 32'(i) * 32'd2 + 32'(b);
        return {v, ~v, v, ~v};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic pulseStart(input logic [31:0] s, input logic [27:0] base, input logic [15:0] count);
        @(negedge sclk);
        seed      = s;
        base_addr = base;
        cmd_count = count;
        start     = 1'b1;
        @(negedge sclk);
        start     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [27:0] base, input int count,
                                 input res_t r);
        cmd_t c;
        for (int i = 0; i < count; i++) begin
            c.cmd  = CMD_WR;
            c.addr = base + 28'(i * 8);
            exp_cmd_q.push_back(c);
            for (int b = 0; b < 2; b++) exp_wdata_q.push_back(pattern(s, i, b));
        end
        for (int i = 0; i < count; i++) begin
            c.cmd  = CMD_RD;
            c.addr = base + 28'(i * 8);
            exp_cmd_q.push_back(c);
        end
        exp_res_q.push_back(r);
        first_wdata_taken = 1'b0;
        pulseStart(s, base, 16'(count));
    endtask

    task automatic resetModel();
        wr_cmds    = 0;
        rd_cmds    = 0;
        rd_beat_no = 0;
        stall_left = 0;
        stall_seen = 0;
        corrupt_at = -1;
        drop_at    = -1;
    endtask

    task automatic waitDone(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge sclk);
            #3;
            if (done) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, 128'(seen), 128'(1));
        @(negedge sclk);
        #3;
        checkOutput({name, "_busy_after"}, 128'(busy), 128'(0));
        checkOutput({name, "_cmd_q_left"}, 128'(exp_cmd_q.size()), 128'(0));
        checkOutput({name, "_wdata_q_left"}, 128'(exp_wdata_q.size()), 128'(0));
        checkOutput({name, "_res_q_left"}, 128'(exp_res_q.size()), 128'(0));
    endtask

    // Controller model: drives ready/read data on the falling edge for the next rising edge.
    initial begin
        cmd_rdy         = 1'b1;
        datain_rdy      = 1'b0;
        read_data_valid = 1'b0;
        read_data       = '0;
        forever begin
            @(negedge sclk);
            if (rst) begin
                wr_left = 0;
                rdq.delete();
                cmd_rdy         = 1'b1;
                datain_rdy      = 1'b0;
                read_data_valid = 1'b0;
                read_data       = '0;
            end else begin
                if (wr_left > 0) begin
                    datain_rdy = 1'b1;
                    mem[{wr_addr, 1'(2 - wr_left)}] = write_data;
                    wr_left--;
                end else begin
                    datain_rdy = 1'b0;
                end
                if (rdq.size() > 0) begin
                    read_data_valid = 1'b1;
                    read_data       = rdq.pop_front();
                end else begin
                    read_data_valid = 1'b0;
                    read_data       = '0;
                end
                if (cmd_valid && cmd == CMD_WR && wr_cmds == 1 && stall_left > 0) begin
                    cmd_rdy = 1'b0;
                    stall_left--;
                end else begin
                    cmd_rdy = 1'b1;
                end
                if (cmd_valid && cmd_rdy) begin
                    if (cmd == CMD_WR) begin
                        wr_left = 2;
                        wr_addr = addr;
                        wr_cmds++;
                    end else begin
                        for (int b = 0; b < 2; b++) begin
                            logic [127:0] d;
                            d = mem.exists({addr, 1'(b)}) ? mem[{addr, 1'(b)}] : 128'd0;
                            if (rd_beat_no == corrupt_at) d = d ^ 128'd1;
                            if (rd_beat_no != drop_at) rdq.push_back(d);
                            rd_beat_no++;
                        end
                        rd_cmds++;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin
        forever begin
            @(negedge sclk);
            #2;
            if (rst) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid)
                    checkOutput("stall_stable", {cmd_valid, cmd, addr}, {1'b1, held_cmd, held_addr});
                if (cmd_valid && !cmd_rdy) begin
                    stall_seen++;
                    held_valid = 1'b1;
                    held_cmd   = cmd;
                    held_addr  = addr;
                end else begin
                    held_valid = 1'b0;
                end
                if (cmd_valid && cmd_rdy) begin
                    checkOutput("cmd_expected", 128'(exp_cmd_q.size() > 0), 128'(1));
                    if (exp_cmd_q.size() > 0) begin
                        cmd_t c;
                        c = exp_cmd_q.pop_front();
                        checkOutput("cmd_code", 128'(cmd), 128'(c.cmd));
                        checkOutput("cmd_addr", 128'(addr), 128'(c.addr));
                    end
                end
                if (datain_rdy) begin
                    checkOutput("wdata_expected", 128'(exp_wdata_q.size() > 0), 128'(1));
                    if (!first_wdata_taken) begin
                        first_wdata_taken = 1'b1;
                        first_wdata       = write_data;
                    end
                    if (exp_wdata_q.size() > 0)
                        checkOutput("write_data", write_data, exp_wdata_q.pop_front());
                end
                if (done) begin
                    checkOutput("res_expected", 128'(exp_res_q.size() > 0), 128'(1));
                    if (exp_res_q.size() > 0) begin
                        res_t r;
                        r = exp_res_q.pop_front();
                        checkOutput("res_pass", 128'(pass), 128'(r.pass));
                        checkOutput("res_err_count", 128'(err_count), 128'(r.err));
                        checkOutput("res_timeout", 128'(timeout), 128'(r.tmo));
                        checkOutput("res_busy", 128'(busy), 128'(0));
`ifdef DDR3_STRESS_ERR_CAPTURE_EN
                        checkOutput("res_err_addr", 128'(err_addr), 128'(r.eaddr));
                        checkOutput("res_err_exp", err_exp, r.eexp);
                        checkOutput("res_err_got", err_got, r.egot);
`endif
                    end
                end
            end
        end
    end

    initial begin
        res_t r;
        int   hi;
        logic seen;

        rst       = 1'b1;
        start     = 1'b0;
        seed      = '0;
        base_addr = '0;
        cmd_count = '0;
        init_done = 1'b1;
        repeat (3) @(negedge sclk);
        #1;
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_done", 128'(done), 128'(0));
        checkOutput("rst_pass", 128'(pass), 128'(0));
        checkOutput("rst_err_count", 128'(err_count), 128'(0));
        checkOutput("rst_timeout", 128'(timeout), 128'(0));
        checkOutput("rst_init_start", 128'(init_start), 128'(0));
        checkOutput("rst_cmd_valid", 128'(cmd_valid), 128'(0));
        checkOutput("rst_cmd", 128'(cmd), 128'(0));
        checkOutput("rst_addr", 128'(addr), 128'(0));
        checkOutput("rst_burst_cnt", 128'(cmd_burst_cnt), 128'(1));
        checkOutput("rst_write_data", write_data, 128'(0));
        checkOutput("rst_mask_ofly", 128'({data_mask, ofly_burst_len}), 128'(0));
        @(negedge sclk);
        rst = 1'b0;

        // Controller init handshake, one command
        resetModel();
        init_done = 1'b0;
        r = '{pass: 1'b1, err: 16'd0, tmo: 1'b0, eaddr: 28'd0, eexp: '0, egot: '0};
        applyStimulus(32'h5, 28'h100, 1, r);
        hi = 0;
        for (int k = 0; k < 50; k++) begin
            if (init_start) hi++;
            @(negedge sclk);
        end
        checkOutput("init_start_cycles", 128'(hi), 128'(50));
        checkOutput("init_no_cmd_yet", 128'(wr_cmds), 128'(0));
        init_done = 1'b1;
        @(negedge sclk);
        #1;
        checkOutput("init_start_drop", 128'(init_start), 128'(0));
        waitDone("init", 500);
        checkOutput("init_writes", 128'(wr_cmds), 128'(1));

        // Ideal controller, four commands, a stray start mid-run
        resetModel();
        r = '{pass: 1'b1, err: 16'd0, tmo: 1'b0, eaddr: 28'd0, eexp: '0, egot: '0};
        applyStimulus(32'h1000, 28'h0, 4, r);
        repeat (10) @(negedge sclk);
        seed      = 32'hDEAD0000;
        base_addr = 28'h500;
        cmd_count = 16'd1;
        start     = 1'b1;
        @(negedge sclk);
        start     = 1'b0;
        waitDone("basic", 500);
        checkOutput("basic_first_beat", first_wdata,
                    {32'h00001000, 32'hFFFFEFFF, 32'h00001000, 32'hFFFFEFFF});
        checkOutput("basic_writes", 128'(wr_cmds), 128'(4));

        // Corrupted read beat 3 (command 1, beat 1)
        resetModel();
        corrupt_at = 3;
        r = '{pass: 1'b0, err: 16'd1, tmo: 1'b0, eaddr: 28'd8,
              eexp: {32'h1003, 32'hFFFFEFFC, 32'h1003, 32'hFFFFEFFC},
              egot: {32'h1003, 32'hFFFFEFFC, 32'h1003, 32'hFFFFEFFD}};
        applyStimulus(32'h1000, 28'h0, 4, r);
        waitDone("corrupt", 500);
        checkOutput("corrupt_pass_held", 128'(pass), 128'(0));

        // Second write command stalled for 20 cycles
        resetModel();
        stall_left = 20;
        r = '{pass: 1'b1, err: 16'd0, tmo: 1'b0, eaddr: 28'd0, eexp: '0, egot: '0};
        applyStimulus(32'hA5A5_0000, 28'h40, 4, r);
        waitDone("stall", 800);
        checkOutput("stall_cycles", 128'(stall_seen), 128'(20));
        checkOutput("stall_writes", 128'(wr_cmds), 128'(4));

        // Last read beat never returned
        resetModel();
        drop_at = 3;
        r = '{pass: 1'b0, err: 16'd1, tmo: 1'b1, eaddr: 28'd0, eexp: '0, egot: '0};
        applyStimulus(32'h2000, 28'h200, 2, r);
        waitDone("timeout", 3000);

        // Address wrap, then reset during the first read
        resetModel();
        r = '{pass: 1'b1, err: 16'd0, tmo: 1'b0, eaddr: 28'd0, eexp: '0, egot: '0};
        applyStimulus(32'h7, 28'hFFFFFF8, 2, r);
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge sclk);
            #3;
            if (rd_cmds >= 1) seen = 1'b1;
        end
        checkOutput("wrap_read_issued", 128'(seen), 128'(1));
        @(posedge sclk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 128'(busy), 128'(0));
        checkOutput("midrst_cmd_valid", 128'(cmd_valid), 128'(0));
        checkOutput("wrap_cmds_left", 128'(exp_cmd_q.size()), 128'(1));
        exp_cmd_q.delete();
        exp_wdata_q.delete();
        exp_res_q.delete();

        // init_start re-arms after reset
        repeat (2) @(negedge sclk);
        rst       = 1'b0;
        init_done = 1'b0;
        pulseStart(32'h0, 28'h0, 16'd1);
        #1;
        checkOutput("init_rearm", 128'(init_start), 128'(1));
        rst = 1'b1;
        repeat (2) @(negedge sclk);
        init_done = 1'b1;
        rst       = 1'b0;
        repeat (2) @(negedge sclk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
